// File: rtl/branch_predictor_pkg.sv
// Package bp_pkg: shared types and constants for the fetch-side branch predictor.
//   - Branch op codes, shared with the execute-stage resolution logic
//   - Default geometry (BP_IDX_BITS, BP_XLEN) and the BTB entry struct
//   - 2-bit counter encodings
// Optional feature macro used elsewhere in the slice: BP_STATS_EN.
package bp_pkg;
  localparam int BP_IDX_BITS = 4;
  localparam int BP_XLEN     = 32;
  localparam int BP_TAG_W    = BP_XLEN - BP_IDX_BITS - 2;

  // Branch ops as produced by execute; anything that is not JUMP_OP trains as a conditional branch.
  localparam logic [4:0] BR_BEQ  = 5'b10000;
  localparam logic [4:0] BR_BNE  = 5'b10001;
  localparam logic [4:0] BR_BLT  = 5'b10100;
  localparam logic [4:0] BR_BGE  = 5'b10101;
  localparam logic [4:0] BR_BLTU = 5'b10110;
  localparam logic [4:0] BR_BGEU = 5'b10111;
  localparam logic [4:0] JUMP_OP = 5'b11111;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0]  target;
    logic [1:0]          ctr;
    logic                jmp;
  } btb_entry_t;
endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup + execute training bundle for branch_predictor.
//   master: the pipeline side (drives pc_f and the upd_* resolution fields)
//   slave : the predictor (returns pred_taken/pred_target, optional stats)
// With BP_STATS_EN defined, stat_resolved/stat_mispred are added.
interface branch_predictor_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] pc_f;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic [4:0]      upd_brop;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_pred_taken;
  logic [XLEN-1:0] upd_pred_target;
`ifdef BP_STATS_EN
  logic [31:0]     stat_resolved;
  logic [31:0]     stat_mispred;
`endif

  modport master (
    output pc_f, upd_valid, upd_pc, upd_brop, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
`ifdef BP_STATS_EN
    input  stat_resolved, stat_mispred,
`endif
    input  pred_taken, pred_target
  );

  modport slave (
    input  pc_f, upd_valid, upd_pc, upd_brop, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
`ifdef BP_STATS_EN
    output stat_resolved, stat_mispred,
`endif
    output pred_taken, pred_target
  );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: next value of a 2-bit saturating counter.
//   ctr   - current counter
//   taken - resolved outcome (+1 when taken, -1 when not)
//   nxt   - saturated next counter
module sat_counter2 (
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] nxt
);
  import bp_pkg::*;

  always_comb begin
    nxt = ctr;
    if (taken && ctr != CTR_ST)        nxt = ctr + 2'd1;
    else if (!taken && ctr != CTR_SNT) nxt = ctr - 2'd1;
  end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with a 2-bit counter per entry.
//   clk, rst - core clock, synchronous active-high reset
//   bp       - branch_predictor_if.slave: pc_f lookup (combinational
//              pred_taken/pred_target) and upd_* training from execute
// Optional macro BP_STATS_EN adds saturating resolved/mispredict counters.
// Entry geometry comes from bp_pkg; IDX_BITS/XLEN must match its defaults.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_BITS = BP_IDX_BITS,
  parameter int XLEN     = BP_XLEN
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);
  localparam int NUM_ENT = 1 << IDX_BITS;
  localparam int TAG_W   = XLEN - IDX_BITS - 2;

  btb_entry_t btb [NUM_ENT];

  // Lookup: reads the current array only, so a same-cycle update is seen next cycle.
  logic [IDX_BITS-1:0] fIdx;
  logic [TAG_W-1:0]    fTag;
  logic                fHit;
  btb_entry_t          fEnt;

  assign fIdx = bp.pc_f[IDX_BITS+1:2];
  assign fTag = bp.pc_f[XLEN-1:IDX_BITS+2];
  assign fEnt = btb[fIdx];
  assign fHit = fEnt.valid && (fEnt.tag == fTag);

  assign bp.pred_taken  = fHit && (fEnt.jmp || fEnt.ctr[1]);
  assign bp.pred_target = bp.pred_taken ? fEnt.target : bp.pc_f + XLEN'(4);

  // Training
  logic [IDX_BITS-1:0] uIdx;
  logic [TAG_W-1:0]    uTag;
  logic                uHit;
  logic                uJmp;
  btb_entry_t          uEnt;
  logic [1:0]          ctrNxt;

  assign uIdx = bp.upd_pc[IDX_BITS+1:2];
  assign uTag = bp.upd_pc[XLEN-1:IDX_BITS+2];
  assign uEnt = btb[uIdx];
  assign uHit = uEnt.valid && (uEnt.tag == uTag);
  assign uJmp = (bp.upd_brop == JUMP_OP);

  sat_counter2 uCtr (
    .ctr   (uEnt.ctr),
    .taken (bp.upd_taken),
    .nxt   (ctrNxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        btb[i].valid  <= 1'b0;
        btb[i].tag    <= '0;
        btb[i].target <= '0;
        btb[i].ctr    <= CTR_WNT;
        btb[i].jmp    <= 1'b0;
      end
    end else if (bp.upd_valid) begin
      if (uHit) begin
        if (uJmp) begin
          // Jumps are unconditional: pin the counter regardless of reported outcome.
          btb[uIdx].ctr    <= CTR_ST;
          btb[uIdx].jmp    <= 1'b1;
          btb[uIdx].target <= bp.upd_target;
        end else begin
          btb[uIdx].ctr <= ctrNxt;
          if (bp.upd_taken) btb[uIdx].target <= bp.upd_target;
        end
      end else if (bp.upd_taken) begin
        // Miss: overwrite whatever lives at this index.
        btb[uIdx].valid  <= 1'b1;
        btb[uIdx].tag    <= uTag;
        btb[uIdx].target <= bp.upd_target;
        btb[uIdx].jmp    <= uJmp;
        btb[uIdx].ctr    <= uJmp ? CTR_ST : CTR_WT;
      end
    end
  end

`ifdef BP_STATS_EN
  logic misPred;
  assign misPred = (bp.upd_pred_taken != bp.upd_taken) ||
                   (bp.upd_taken && (bp.upd_pred_target != bp.upd_target));

  always_ff @(posedge clk) begin
    if (rst) begin
      bp.stat_resolved <= '0;
      bp.stat_mispred  <= '0;
    end else if (bp.upd_valid) begin
      if (bp.stat_resolved != '1) bp.stat_resolved <= bp.stat_resolved + 32'd1;
      if (misPred && bp.stat_mispred != '1) bp.stat_mispred <= bp.stat_mispred + 32'd1;
    end
  end

  logic unusedBits;
  assign unusedBits = ^{bp.pc_f[1:0], bp.upd_pc[1:0]};
`else
  // Prediction inputs carried down the pipe only feed the stats counters.
  logic unusedBits;
  assign unusedBits = ^{bp.pc_f[1:0], bp.upd_pc[1:0], bp.upd_pred_taken, bp.upd_pred_target};
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: lookup expectations are pushed to a
// scoreboard queue when pc_f is driven and popped/compared once it has settled.
module tb_branch_predictor;
  import bp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_if #(.XLEN(32)) bpIf ();

  branch_predictor #(.IDX_BITS(4), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bpIf.slave)
  );

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   nChk = 0;
  int   nErr = 0;
  int   expRes = 0;
  int   expMis = 0;

  // Drive pc_f and push the expected prediction.
  task automatic drive_lookup(input logic [31:0] pc, input logic t, input logic [31:0] tg, input string nm);
    exp_t e;
    bpIf.pc_f = pc;
    e.pc = pc; e.taken = t; e.target = tg; e.name = nm;
    sb.push_back(e);
  endtask

  // Pop the oldest expectation once the combinational lookup has settled.
  task automatic pop_compare();
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      nChk++; nErr++;
      $display("FAIL scoreboard_empty: got no expectation, required one");
      return;
    end
    e = sb.pop_front();
    nChk++;
    if (bpIf.pred_taken !== e.taken || bpIf.pred_target !== e.target) begin
      nErr++;
      $display("FAIL %s: pc=%h got taken=%b target=%h, required taken=%b target=%h",
               e.name, e.pc, bpIf.pred_taken, bpIf.pred_target, e.taken, e.target);
    end
  endtask

  task automatic look(input logic [31:0] pc, input logic t, input logic [31:0] tg, input string nm);
    drive_lookup(pc, t, tg, nm);
    pop_compare();
  endtask

  // One resolution, held across a single rising edge.
  task automatic upd(input logic [31:0] pc, input logic [4:0] op, input logic t, input logic [31:0] tg,
                     input logic pt = 1'b0, input logic [31:0] ptg = 32'h0);
    bpIf.upd_valid = 1'b1; bpIf.upd_pc = pc; bpIf.upd_brop = op;
    bpIf.upd_taken = t; bpIf.upd_target = tg;
    bpIf.upd_pred_taken = pt; bpIf.upd_pred_target = ptg;
    if (!rst) begin
      expRes++;
      if (pt != t || (t && ptg != tg)) expMis++;
    end
    @(posedge clk); #1;
    bpIf.upd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    expRes = 0; expMis = 0;
  endtask

  task automatic check_stats(input string nm);
`ifdef BP_STATS_EN
    nChk++;
    if (bpIf.stat_resolved !== 32'(expRes) || bpIf.stat_mispred !== 32'(expMis)) begin
      nErr++;
      $display("FAIL %s: got resolved=%0d mispred=%0d, required resolved=%0d mispred=%0d",
               nm, bpIf.stat_resolved, bpIf.stat_mispred, expRes, expMis);
    end
`else
    if (nm.len() < 0) $display("%s", nm);
`endif
  endtask

  task automatic test_reset();
    do_reset();
    look(32'h100, 1'b0, 32'h104, "reset_miss");
    look(32'hFFFF_FFFC, 1'b0, 32'h0, "reset_wrap");
    check_stats("reset_stats");
  endtask

  task automatic test_branch_train();
    upd(32'h100, BR_BEQ, 1'b1, 32'h80);
    look(32'h100, 1'b1, 32'h80, "alloc_taken");
    upd(32'h100, BR_BEQ, 1'b0, 32'h80);              // 10 -> 01
    look(32'h100, 1'b0, 32'h104, "one_nt");
    upd(32'h100, BR_BNE, 1'b0, 32'h80);              // 00
    upd(32'h100, BR_BNE, 1'b0, 32'h80);              // stays 00
    upd(32'h100, BR_BLT, 1'b1, 32'h80);              // 01
    look(32'h100, 1'b0, 32'h104, "sat_low");
    upd(32'h100, BR_BGE, 1'b1, 32'h88);              // 10, new target
    look(32'h100, 1'b1, 32'h88, "two_taken");
    upd(32'h100, BR_BLTU, 1'b1, 32'h88);             // 11
    upd(32'h100, 5'b00011, 1'b1, 32'h88);            // stays 11 (unknown op = branch)
    look(32'h100, 1'b1, 32'h88, "st_taken");
    upd(32'h100, BR_BGEU, 1'b0, 32'h88);             // 10: proves it was 11
    look(32'h100, 1'b1, 32'h88, "sat_high");
    upd(32'h100, BR_BEQ, 1'b0, 32'h88);              // 01
    look(32'h100, 1'b0, 32'h104, "back_to_wnt");
  endtask

  task automatic test_jump();
    upd(32'h200, JUMP_OP, 1'b1, 32'h400);
    look(32'h200, 1'b1, 32'h400, "jump_alloc");
    for (int i = 0; i < 3; i++) upd(32'h200, JUMP_OP, 1'b0, 32'h400);
    look(32'h200, 1'b1, 32'h400, "jump_sticky");
  endtask

  task automatic test_alias();
    upd(32'h100, BR_BEQ, 1'b1, 32'h80);
    upd(32'h140, BR_BEQ, 1'b1, 32'h10);
    look(32'h100, 1'b0, 32'h104, "alias_evict");
    look(32'h140, 1'b1, 32'h10, "alias_hit");
    upd(32'h180, BR_BEQ, 1'b0, 32'h20);
    look(32'h180, 1'b0, 32'h184, "nt_no_alloc");
    look(32'h140, 1'b1, 32'h10, "nt_kept");
  endtask

  task automatic test_same_cycle();
    bpIf.upd_valid = 1'b1; bpIf.upd_pc = 32'h300; bpIf.upd_brop = BR_BNE;
    bpIf.upd_taken = 1'b1; bpIf.upd_target = 32'h500;
    bpIf.upd_pred_taken = 1'b0; bpIf.upd_pred_target = 32'h0;
    expRes++; expMis++;
    look(32'h300, 1'b0, 32'h304, "same_cycle_pre");
    @(posedge clk); #1;
    bpIf.upd_valid = 1'b0;
    look(32'h300, 1'b1, 32'h500, "same_cycle_post");
  endtask

  task automatic test_reset_drop();
    rst = 1'b1;
    upd(32'h344, BR_BEQ, 1'b1, 32'h600);
    rst = 1'b0;
    expRes = 0; expMis = 0;
    look(32'h344, 1'b0, 32'h348, "rst_drop");
    look(32'h300, 1'b0, 32'h304, "rst_clear");
    look(32'h200, 1'b0, 32'h204, "rst_clear_jmp");
    check_stats("rst_stats");
  endtask

  task automatic test_stats();
    upd(32'h10, BR_BEQ, 1'b1, 32'h40, 1'b0, 32'h0);   // direction miss
    upd(32'h10, BR_BEQ, 1'b0, 32'h40, 1'b1, 32'h40);  // direction miss
    upd(32'h10, BR_BEQ, 1'b1, 32'h44, 1'b1, 32'h40);  // target miss
    upd(32'h10, BR_BEQ, 1'b1, 32'h44, 1'b1, 32'h44);  // correct
    upd(32'h10, BR_BEQ, 1'b0, 32'h44, 1'b0, 32'h99);  // correct, target ignored
`ifdef BP_STATS_EN
    nChk++;
    if (bpIf.stat_resolved !== 32'd5 || bpIf.stat_mispred !== 32'd3) begin
      nErr++;
      $display("FAIL stats_5_3: got resolved=%0d mispred=%0d, required 5 and 3",
               bpIf.stat_resolved, bpIf.stat_mispred);
    end
`endif
    check_stats("stats_model");
  endtask

  initial begin
    bpIf.pc_f = '0; bpIf.upd_valid = 1'b0; bpIf.upd_pc = '0; bpIf.upd_brop = '0;
    bpIf.upd_taken = 1'b0; bpIf.upd_target = '0;
    bpIf.upd_pred_taken = 1'b0; bpIf.upd_pred_target = '0;
    @(posedge clk); #1;
    test_reset();
    test_branch_train();
    test_jump();
    test_alias();
    test_same_cycle();
    test_reset_drop();
    test_stats();
    if (sb.size() != 0) begin
      nChk++; nErr++;
      $display("FAIL scoreboard_drain: got %0d leftover, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nErr);
    $finish;
  end
endmodule
